// File: rtl/hold_bank.sv
// hold_bank: multi-slot hold store for the game controller.
// Each hold request runs IDLE -> EXEC -> RESP and is limited by a per-piece hold budget.
module hold_bank #(
    parameter int                NUM_SLOTS       = 2,
    parameter int                IDX_W           = 3,
    parameter logic [IDX_W-1:0]  EMPTY_IDX       = 3'b111,
    parameter int                HOLDS_PER_PIECE = 1,
    localparam int               SLOT_W          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int               CNT_W           = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       game_reset,
    input  logic                       hold_req,
    input  logic [SLOT_W-1:0]          hold_slot,
    input  logic [IDX_W-1:0]           curr_idx,
    input  logic                       piece_locked,
    output logic                       hold_ack,
    output logic                       hold_reject,
    output logic                       swap_valid,
    output logic [IDX_W-1:0]           new_idx,
    output logic [NUM_SLOTS*IDX_W-1:0] slots_flat,
    output logic                       hold_used,
    output logic [CNT_W-1:0]           holds_left
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [CNT_W-1:0] HOLDS_INIT = CNT_W'(HOLDS_PER_PIECE);
    // One extra bit so that NUM_SLOTS itself is representable for the range test.
    localparam logic [SLOT_W:0]  SLOT_LIMIT = (SLOT_W+1)'(NUM_SLOTS);

    state_t            state;
    state_t            state_nxt;
    logic [SLOT_W-1:0] slot_lat;
    logic [IDX_W-1:0]  curr_lat;
    logic [IDX_W-1:0]  slots [NUM_SLOTS];
    logic [IDX_W-1:0]  old_idx;
    logic              accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (game_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        old_idx   = EMPTY_IDX;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (slot_lat == SLOT_W'(i))
                old_idx = slots[i];
        accept = (state == EXEC) && (holds_left != '0) &&
                 ({1'b0, slot_lat} < SLOT_LIMIT) && (curr_lat != EMPTY_IDX);
        case (state)
            IDLE:    if (hold_req) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                slots[i] <= EMPTY_IDX;
            holds_left  <= HOLDS_INIT;
            new_idx     <= EMPTY_IDX;
            swap_valid  <= 1'b0;
            hold_ack    <= 1'b0;
            hold_reject <= 1'b0;
            slot_lat    <= '0;
            curr_lat    <= EMPTY_IDX;
        end else if (game_reset) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                slots[i] <= EMPTY_IDX;
            holds_left  <= HOLDS_INIT;
            new_idx     <= EMPTY_IDX;
            swap_valid  <= 1'b0;
            hold_ack    <= 1'b0;
            hold_reject <= 1'b0;
            slot_lat    <= '0;
            curr_lat    <= EMPTY_IDX;
        end else begin
            // Response pulses are registered out of EXEC so they land in RESP.
            hold_ack    <= accept;
            hold_reject <= (state == EXEC) && !accept;
            if (state == IDLE && hold_req) begin
                slot_lat <= hold_slot;
                curr_lat <= curr_idx;
            end
            if (accept) begin
                new_idx    <= old_idx;
                swap_valid <= (old_idx != EMPTY_IDX);
                for (int i = 0; i < NUM_SLOTS; i++)
                    if (slot_lat == SLOT_W'(i))
                        slots[i] <= curr_lat;
            end
            // A refill overrides the decrement of a request evaluated in the same cycle.
            if (piece_locked)
                holds_left <= HOLDS_INIT;
            else if (accept)
                holds_left <= holds_left - CNT_W'(1);
        end
    end

    always_comb begin
        slots_flat = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            slots_flat[i*IDX_W +: IDX_W] = slots[i];
    end

    assign hold_used = (holds_left == '0);

endmodule

// File: tb/tb_hold_bank.sv
// Bench for hold_bank: two instances (2 slots/1 hold, 3 slots/2 holds) checked against
// a transaction-level model of slot contents, hold budget and responses.
module tb_hold_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       req      [2];
    logic [1:0] slot_drv [2];
    logic [2:0] curr_drv [2];
    logic       lock     [2];
    logic       grst     [2];

    logic       ack  [2];
    logic       rej  [2];
    logic       swap [2];
    logic [2:0] newi [2];
    logic       used [2];
    logic [2:0] hl   [2];
    logic [5:0] sf_a;
    logic [8:0] sf_b;

    int n_chk  = 0;
    int n_fail = 0;

    int         nslots [2] = '{2, 3};
    int         hpp    [2] = '{1, 2};
    logic [2:0] m_slots [2][4];
    int         m_holds [2];
    logic [2:0] m_new   [2];
    logic       m_swap  [2];

    always #5 clk = ~clk;

    hold_bank #(.NUM_SLOTS(2), .HOLDS_PER_PIECE(1)) dut_a (
        .clk(clk), .rst(rst), .game_reset(grst[0]), .hold_req(req[0]),
        .hold_slot(slot_drv[0][0:0]), .curr_idx(curr_drv[0]), .piece_locked(lock[0]),
        .hold_ack(ack[0]), .hold_reject(rej[0]), .swap_valid(swap[0]), .new_idx(newi[0]),
        .slots_flat(sf_a), .hold_used(used[0]), .holds_left(hl[0])
    );

    hold_bank #(.NUM_SLOTS(3), .HOLDS_PER_PIECE(2)) dut_b (
        .clk(clk), .rst(rst), .game_reset(grst[1]), .hold_req(req[1]),
        .hold_slot(slot_drv[1]), .curr_idx(curr_drv[1]), .piece_locked(lock[1]),
        .hold_ack(ack[1]), .hold_reject(rej[1]), .swap_valid(swap[1]), .new_idx(newi[1]),
        .slots_flat(sf_b), .hold_used(used[1]), .holds_left(hl[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear(input int d);
        for (int i = 0; i < 4; i++)
            m_slots[d][i] = 3'd7;
        m_holds[d] = hpp[d];
        m_new[d]   = 3'd7;
        m_swap[d]  = 1'b0;
    endtask

    task automatic check_state(input int d);
        logic [2:0] got;
        for (int i = 0; i < nslots[d]; i++) begin
            got = (d == 0) ? 3'(sf_a >> (3*i)) : 3'(sf_b >> (3*i));
            chk($sformatf("slot%0d_dut%0d", i, d), 32'(got), 32'(m_slots[d][i]));
        end
        chk($sformatf("holds_left_dut%0d", d), 32'(hl[d]), 32'(m_holds[d]));
        chk($sformatf("hold_used_dut%0d", d), 32'(used[d]), 32'(m_holds[d] == 0));
        chk($sformatf("new_idx_dut%0d", d), 32'(newi[d]), 32'(m_new[d]));
    endtask

    // Drives a request in cycle N, optional refill in N or N+1, optional abort in N+1.
    task automatic do_req(input int d, input int slot, input logic [2:0] curr,
                          input bit lock_idle, input bit lock_exec, input bit gr_exec);
        bit         ok;
        logic [2:0] old;
        req[d]      = 1'b1;
        slot_drv[d] = 2'(slot);
        curr_drv[d] = curr;
        lock[d]     = lock_idle;
        @(negedge clk);
        if (lock_idle)
            m_holds[d] = hpp[d];
        chk("exec_no_pulse", 32'({ack[d], rej[d]}), 32'd0);
        req[d]      = gr_exec ? 1'b0 : 1'($urandom);
        slot_drv[d] = 2'($urandom);
        curr_drv[d] = 3'($urandom);
        lock[d]     = lock_exec;
        grst[d]     = gr_exec;
        @(negedge clk);
        ok = (m_holds[d] > 0) && (slot < nslots[d]) && (curr != 3'd7);
        if (gr_exec) begin
            model_clear(d);
            chk("abort_no_pulse", 32'({ack[d], rej[d]}), 32'd0);
        end else begin
            if (ok) begin
                old             = m_slots[d][slot];
                m_new[d]        = old;
                m_swap[d]       = (old != 3'd7);
                m_slots[d][slot] = curr;
                m_holds[d]--;
            end
            if (lock_exec)
                m_holds[d] = hpp[d];
            chk("hold_ack", 32'(ack[d]), 32'(ok));
            chk("hold_reject", 32'(rej[d]), 32'(!ok));
            if (ok)
                chk("swap_valid", 32'(swap[d]), 32'(m_swap[d]));
        end
        check_state(d);
        req[d]  = gr_exec ? 1'b0 : 1'($urandom);
        lock[d] = 1'b0;
        grst[d] = 1'b0;
        @(negedge clk);
        req[d] = 1'b0;
        chk("resp_one_cycle", 32'({ack[d], rej[d]}), 32'd0);
    endtask

    task automatic pulse_lock(input int d);
        lock[d] = 1'b1;
        @(negedge clk);
        lock[d]    = 1'b0;
        m_holds[d] = hpp[d];
        check_state(d);
    endtask

    task automatic pulse_grst(input int d);
        grst[d] = 1'b1;
        @(negedge clk);
        grst[d] = 1'b0;
        model_clear(d);
        check_state(d);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; slot_drv[d] = 2'd0; curr_drv[d] = 3'd0;
            lock[d] = 1'b0; grst[d] = 1'b0;
            model_clear(d);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // After reset: empty slots, full budget, quiet for 10 cycles.
        chk("rst_slots_a", 32'(sf_a), 32'h3F);
        chk("rst_slots_b", 32'(sf_b), 32'h1FF);
        chk("rst_holds_a", 32'(hl[0]), 32'd1);
        chk("rst_holds_b", 32'(hl[1]), 32'd2);
        chk("rst_used_a", 32'(used[0]), 32'd0);
        chk("rst_new_a", 32'(newi[0]), 32'd7);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_quiet_a", 32'({ack[0], rej[0]}), 32'd0);
            chk("rst_quiet_b", 32'({ack[1], rej[1]}), 32'd0);
        end

        // Hold T into empty slot 0.
        do_req(0, 0, 3'd5, 0, 0, 0);
        chk("t2_new", 32'(newi[0]), 32'd7);
        chk("t2_swap", 32'(swap[0]), 32'd0);
        chk("t2_slot0", 32'(sf_a[2:0]), 32'd5);
        chk("t2_used", 32'(used[0]), 32'd1);

        // Budget spent: reject, nothing changes.
        do_req(0, 1, 3'd3, 0, 0, 0);
        chk("t3_slots", 32'(sf_a), 32'h3D);
        chk("t3_new", 32'(newi[0]), 32'd7);

        // Refill, then swap I with the held T.
        pulse_lock(0);
        do_req(0, 0, 3'd0, 0, 0, 0);
        chk("t4_swap", 32'(swap[0]), 32'd1);
        chk("t4_new", 32'(newi[0]), 32'd5);
        chk("t4_slot0", 32'(sf_a[2:0]), 32'd0);

        // Refill in the same IDLE cycle as the request lets it through.
        do_req(0, 1, 3'd3, 1, 0, 0);
        chk("lock_idle_slot1", 32'(sf_a[5:3]), 32'd3);

        // Abort in EXEC, then a fresh hold behaves like the first one.
        do_req(0, 0, 3'd2, 0, 0, 1);
        chk("t6_slots", 32'(sf_a), 32'h3F);
        do_req(0, 0, 3'd5, 0, 0, 0);
        chk("t6_new", 32'(newi[0]), 32'd7);
        chk("t6_slot0", 32'(sf_a[2:0]), 32'd5);

        // Refill during EXEC wins over the decrement.
        pulse_lock(0);
        do_req(0, 1, 3'd4, 0, 1, 0);
        chk("lock_exec_holds", 32'(hl[0]), 32'd1);
        do_req(0, 1, 3'd6, 0, 0, 0);
        chk("lock_exec_new", 32'(newi[0]), 32'd4);

        // Three slots, two holds per piece; slot 3 is never valid.
        do_req(1, 2, 3'd4, 0, 0, 0);
        chk("t5_slot2", 32'(sf_b[8:6]), 32'd4);
        do_req(1, 1, 3'd6, 0, 0, 0);
        chk("t5_slot1", 32'(sf_b[5:3]), 32'd6);
        do_req(1, 0, 3'd1, 0, 0, 0);
        chk("t5_used", 32'(used[1]), 32'd1);
        pulse_lock(1);
        do_req(1, 3, 3'd2, 0, 0, 0);
        chk("t5_slot3_holds", 32'(hl[1]), 32'd2);

        // Randomized traffic on both instances.
        for (int it = 0; it < 160; it++) begin
            int d;
            int op;
            d  = it % 2;
            op = $urandom_range(0, 11);
            if (op == 0)
                pulse_grst(d);
            else if (op == 1)
                pulse_lock(d);
            else
                do_req(d, $urandom_range(0, (d == 0) ? 1 : 3), 3'($urandom_range(0, 7)),
                       $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
